pc_unit_ras: RTL
================

Name: pc_unit_ras

Overview:
- Parametrised next-generation program-counter unit for the RISC-V core.
- Holds the fetch PC and selects the next PC: sequential, branch, indirect jump, call, return or pipeline flush.
- Adds a circular return-address stack (RAS) so returns are redirected without waiting on rs1.
- Sits at the fetch stage. It is driven by the EX-stage redirect signals and by the hazard unit (en/flush).

Parameters:
- XLEN, 32: width of the PC, pc_EX, imm, rs1, flush_pc and RAS entries.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- RAS_DEPTH, 4: number of RAS entries. Power of two, 2..16.
- INSTR_BYTES, 4: increment for sequential fetch and for the link address.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable. 0 = stall: hold PC and RAS.
- flush  in  1  pipeline flush; loads flush_pc. Overrides en and sel.
- flush_pc  in  XLEN  flush/trap target.
- sel  in  3  next-PC mode, encoding below.
- pc_EX  in  XLEN  PC of the instruction in EX.
- imm  in  XLEN  sign-extended immediate from EX.
- rs1  in  XLEN  forwarded rs1 value from EX.
- pc  out  XLEN  current fetch PC (registered).
- pc_misaligned  out  1  combinational; equals pc[1] | pc[0].
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.

Behaviour:
- Reset (rst=1 at posedge): pc <= RESET_VECTOR, ras_count <= 0, stack pointer <= 0. Entry contents are don't-care.
- After reset: pc_misaligned = |RESET_VECTOR[1:0], ras_empty=1, ras_full=0.
- Priority each posedge: rst > flush > !en > sel.
- Flush: pc <= flush_pc. RAS is unchanged, regardless of en or sel.
- Stall (en=0, no flush): pc and RAS hold.
- sel encoding when en=1:
  - 000 SEQ: pc <= pc + INSTR_BYTES.
  - 001 BRANCH: pc <= pc_EX + imm.
  - 010 JALR: pc <= (rs1 + imm) & ~1. Bit 0 is cleared.
  - 011 CALL: pc <= pc_EX + imm, and push pc_EX + INSTR_BYTES.
  - 100 RET: if RAS is not empty, pc <= top entry and pop. If empty, pc <= (rs1 + imm) & ~1 and the RAS is unchanged.
  - 101..111 reserved: pc and RAS hold, same as a stall.
- All adds are modulo 2^XLEN. Wrap-around is silent, e.g. FFFF_FFFC + 4 = 0000_0000.
- The new PC is visible on pc one cycle after the qualifying edge. There is no combinational path from inputs to pc.
- RAS push:
  - Entry is written at the pointer, then the pointer increments modulo RAS_DEPTH.
  - ras_count increments, saturating at RAS_DEPTH.
  - Push while full overwrites the oldest entry (circular). The newest RAS_DEPTH entries are retained.
- RAS pop:
  - Pointer decrements modulo RAS_DEPTH; the returned entry is the one at the new pointer.
  - ras_count decrements.
  - Popping after overflow returns the newest RAS_DEPTH addresses in LIFO order, then reports empty.
- RAS read is from registered state only. The pop target is the entry as it was before the edge.
- pc_misaligned is not a trap. The pc is loaded with the target anyway. The trap unit samples pc_misaligned and responds with flush.
- ras_count/ras_empty/ras_full are registered-state derived and update in the same cycle as pc.

Test Plan:
- Reset and sequential fetch: hold rst=1 for 2 cycles with RESET_VECTOR=0x100, then sel=000, en=1 for 3 cycles -> pc=0x100, 0x104, 0x108, 0x10C; ras_empty=1.
- Stall and flush priority:
  - pc=0x200, en=0, sel=001 -> pc holds 0x200.
  - Then flush=1 with flush_pc=0x800, en=0 -> pc=0x800 next cycle.
- Branch and JALR:
  - pc_EX=0x1000, imm=0xFFFF_FFF0, sel=001 -> pc=0x0FF0.
  - rs1=0x2001, imm=0x4, sel=010 -> pc=0x2004.
  - rs1=0x2002, imm=0, sel=010 -> pc=0x2002 and pc_misaligned=1.
- Call/return nesting:
  - CALL at pc_EX=0x40 (imm=0x100) -> pc=0x140, ras_count=1.
  - CALL at pc_EX=0x150 (imm=0x100) -> pc=0x250, ras_count=2.
  - RET -> pc=0x154, then RET -> pc=0x44, ras_empty=1.
- RAS overflow (RAS_DEPTH=4):
  - 5 CALLs with link addresses 0x4, 0x8, 0xC, 0x10, 0x14 -> ras_full=1, ras_count=4.
  - 4 RETs -> pc=0x14, 0x10, 0xC, 0x8.
  - 5th RET with rs1=0x300, imm=0 -> pc=0x300 (fallback), ras_count=0.
- Wrap and reserved:
  - pc=0xFFFF_FFFC, sel=000 -> pc=0x0000_0000.
  - sel=110 -> pc and ras_count unchanged.

Source files
------------

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with next-PC selection and a circular return-address stack.
// Returns are redirected from the stack top, so they do not wait on rs1.
module pc_unit_ras #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4,
  parameter int unsigned      INSTR_BYTES  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         flush,
  input  logic [XLEN-1:0]              flush_pc,
  input  logic [2:0]                   sel,
  input  logic [XLEN-1:0]              pc_EX,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              rs1,
  output logic [XLEN-1:0]              pc,
  output logic                         pc_misaligned,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [XLEN-1:0] Inc    = XLEN'(INSTR_BYTES);
  localparam logic [CntW-1:0] DepthC = CntW'(RAS_DEPTH);

  localparam logic [2:0] SelSeq    = 3'b000;
  localparam logic [2:0] SelBranch = 3'b001;
  localparam logic [2:0] SelJalr   = 3'b010;
  localparam logic [2:0] SelCall   = 3'b011;
  localparam logic [2:0] SelRet    = 3'b100;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PtrW-1:0] sp_q, sp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];

  logic            push;
  logic [XLEN-1:0] push_data;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] ind_sum;
  logic [XLEN-1:0] ind_target;
  logic [PtrW-1:0] sp_dec;
  logic            cnt_zero;
  logic            cnt_full;

  assign rel_target = pc_EX + imm;
  assign ind_sum    = rs1 + imm;
  assign ind_target = {ind_sum[XLEN-1:1], 1'b0};
  // Power-of-two depth: natural pointer wrap implements the circular buffer.
  assign sp_dec     = sp_q - 1'b1;
  assign cnt_zero   = (cnt_q == '0);
  assign cnt_full   = (cnt_q == DepthC);

  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = pc_EX + Inc;
    if (flush) begin
      pc_d = flush_pc;
    end else if (en) begin
      case (sel)
        SelSeq:    pc_d = pc_q + Inc;
        SelBranch: pc_d = rel_target;
        SelJalr:   pc_d = ind_target;
        SelCall: begin
          pc_d  = rel_target;
          push  = 1'b1;
          sp_d  = sp_q + 1'b1;
          cnt_d = cnt_full ? cnt_q : cnt_q + 1'b1;
        end
        SelRet: begin
          if (!cnt_zero) begin
            pc_d  = ras_q[sp_dec];
            sp_d  = sp_dec;
            cnt_d = cnt_q - 1'b1;
          end else begin
            pc_d = ind_target;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents need no reset; only count and pointer define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      ras_q[sp_q] <= push_data;
    end
  end

  assign pc            = pc_q;
  assign pc_misaligned = pc_q[1] | pc_q[0];
  assign ras_count     = cnt_q;
  assign ras_empty     = cnt_zero;
  assign ras_full      = cnt_full;

endmodule
